wts_ram_sequencer: RTL and testbench

- Time-division access sequencer sitting directly upstream of the 384x8 wave-table RAM (12 channels x 32 bytes; address = ch*32 + index).
- Drives the RAM's sram_we/sram_a/sram_d and consumes sram_q.
- Interleaves fixed-slot wave-sample fetches for every channel with one CPU read/write slot per frame.
- Returns per-channel samples to the tone generators and CPU read data to the bus interface.

---
 rtl/wts_ram_sequencer_if.sv | 22 ++
 rtl/wts_ram_sequencer.sv | 130 +++++++++++++
 tb/tb_wts_ram_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wts_ram_sequencer_if.sv
// ============================================================================
// wts_ram_sequencer_if : CPU request/acknowledge bus into the wave-table RAM
// Rev 1.0
// ============================================================================
`default_nettype none

interface wts_ram_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              ack;
  logic [DATA_W-1:0] q;

  modport master (output req, we, a, d, input ack, q);
  modport slave  (input req, we, a, d, output ack, q);
endinterface

`default_nettype wire

// File: rtl/wts_ram_sequencer.sv
// ============================================================================
// wts_ram_sequencer : time-division wave-fetch / CPU-access slot sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module wts_ram_sequencer #(
  parameter int NUM_CH     = 12,
  parameter int WAVE_LEN_W = 5,
  parameter int RAM_WORDS  = 384
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic [NUM_CH*WAVE_LEN_W-1:0] ch_phase,
  input  wire logic [NUM_CH-1:0]            ch_enable,
  output logic                              wave_valid,
  output logic [3:0]                        wave_ch,
  output logic [7:0]                        wave_data,
  wts_ram_sequencer_if.slave                cpu,
  output logic                              sram_we,
  output logic [8:0]                        sram_a,
  output logic [7:0]                        sram_d,
  input  wire logic [7:0]                   sram_q
);

  localparam int SLOT_W = 4;
  localparam int ADDR_W = 9;
  localparam logic [SLOT_W-1:0] CPU_SLOT = SLOT_W'(NUM_CH);

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WAVE = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_WR   = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic              oor;
    logic              en;
    logic [SLOT_W-1:0] ch;
  } tag_t;

  logic [SLOT_W-1:0]     r_slot;
  logic [SLOT_W-1:0]     w_slot_nxt;
  logic                  r_pending;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_a;
  logic [7:0]            r_d;
  tag_t                  r_tag1;
  tag_t                  r_tag2;
  tag_t                  w_issue;
  logic [7:0]            r_wave_data;
  logic [7:0]            r_cpu_q;
  logic [WAVE_LEN_W-1:0] w_phase;
  logic                  w_in_range;
  logic                  w_accept;

  assign w_in_range = (r_a < ADDR_W'(RAM_WORDS));
  assign w_accept   = cpu.req && !r_pending && !cpu.ack;

  // State register: slot counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_slot <= '0;
    else       r_slot <= w_slot_nxt;
  end

  // Next-state logic
  always_comb begin
    w_slot_nxt = (r_slot == CPU_SLOT) ? '0 : r_slot + SLOT_W'(1);
  end

  // Output logic: RAM port drive and the tag describing this cycle's access
  always_comb begin
    sram_we = 1'b0;
    sram_a  = '0;
    sram_d  = '0;
    w_phase = '0;
    w_issue = '0;
    if (r_slot != CPU_SLOT) begin
      w_phase      = ch_phase[r_slot*WAVE_LEN_W +: WAVE_LEN_W];
      sram_a       = (ADDR_W'(r_slot) << WAVE_LEN_W) | ADDR_W'(w_phase);
      w_issue.kind = K_WAVE;
      w_issue.ch   = r_slot;
      w_issue.en   = ch_enable[r_slot];
    end else if (r_pending) begin
      w_issue.kind = r_we ? K_WR : K_RD;
      w_issue.oor  = !w_in_range;
      if (w_in_range) begin
        sram_a  = r_a;
        sram_d  = r_d;
        sram_we = r_we;
      end
    end
  end

  // Pending clears on the edge that raises cpu_ack for either access kind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_we        <= 1'b0;
      r_a         <= '0;
      r_d         <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      r_wave_data <= '0;
      r_cpu_q     <= '0;
    end else begin
      r_tag1 <= w_issue;
      r_tag2 <= r_tag1;
      if (r_tag1.kind == K_WAVE) r_wave_data <= sram_q;
      if (r_tag1.kind == K_RD)   r_cpu_q     <= r_tag1.oor ? 8'hFF : sram_q;
      if (w_accept) begin
        r_pending <= 1'b1;
        r_we      <= cpu.we;
        r_a       <= cpu.a;
        r_d       <= cpu.d;
      end else if (w_issue.kind == K_WR || r_tag1.kind == K_RD) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign wave_valid = (r_tag2.kind == K_WAVE) && r_tag2.en;
  assign wave_ch    = r_tag2.ch;
  assign wave_data  = r_wave_data;
  assign cpu.ack    = (r_tag1.kind == K_WR) || (r_tag2.kind == K_RD);
  assign cpu.q      = r_cpu_q;

endmodule

`default_nettype wire

// File: tb/tb_wts_ram_sequencer.sv
// ============================================================================
// tb_wts_ram_sequencer : directed self-checking bench with a 384x8 RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wts_ram_sequencer;

  logic        clk;
  logic        reset;
  logic [59:0] ch_phase;
  logic [11:0] ch_enable;
  logic        wave_valid;
  logic [3:0]  wave_ch;
  logic [7:0]  wave_data;
  logic        sram_we;
  logic [8:0]  sram_a;
  logic [7:0]  sram_d;
  logic [7:0]  sram_q;
  logic        ld;

  int total;
  int bad;
  int cyc;

  logic [7:0] mem [0:383];

  wts_ram_sequencer_if cpu ();

  wts_ram_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ch_phase   (ch_phase),
    .ch_enable  (ch_enable),
    .wave_valid (wave_valid),
    .wave_ch    (wave_ch),
    .wave_data  (wave_data),
    .cpu        (cpu),
    .sram_we    (sram_we),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preload: byte[ch*32] = ch+0x10, every other byte = addr ^ 0x5A
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 384; i++)
        mem[i] <= (i % 32 == 0) ? 8'(i / 32 + 16) : (8'(i) ^ 8'h5A);
    end else if (sram_we) begin
      if (sram_a < 9'd384) mem[sram_a] <= sram_d;
    end else begin
      sram_q <= (sram_a < 9'd384) ? mem[sram_a] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    while ((cyc % 13) != s && n < 13) begin
      tick;
      n++;
    end
  endtask

  task automatic cpu_op(input logic we, input logic [8:0] a, input logic [8:0] a2,
                        input logic [7:0] d, output logic [7:0] q, output int lat,
                        output int we_n, output logic [8:0] we_a, output int we_lat);
    int n;
    n = 0; we_n = 0; we_a = '0; we_lat = -1; lat = -1; q = '0;
    cpu.req = 1'b1; cpu.we = we; cpu.a = a; cpu.d = d;
    while (n < 20) begin
      if (sram_we) begin
        we_n++;
        we_a   = sram_a;
        we_lat = n;
      end
      if (cpu.ack) begin
        lat = n;
        q   = cpu.q;
        break;
      end
      tick;
      n++;
      if (n == 1) cpu.a = a2;
    end
    cpu.req = 1'b0;
    check("ack_seen", 32'(lat >= 0), 1);
    tick;
    check("ack_one_cycle", cpu.ack, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    logic [8:0] wa;
    int lat, wn, wl, cnt_other, cnt_ch0, cnt_ack;

    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; ld = 1'b1;
    ch_phase = '0; ch_enable = 12'hFFF;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.a = '0; cpu.d = '0;
    repeat (3) tick;
    ld = 1'b0;
    tick;

    check("rst_wave_valid", wave_valid, 0);
    check("rst_wave_ch", wave_ch, 0);
    check("rst_wave_data", wave_data, 0);
    check("rst_cpu_ack", cpu.ack, 0);
    check("rst_cpu_q", cpu.q, 0);
    check("rst_sram_we", sram_we, 0);

    // 1: full frame of fetches, all channels enabled, phase 0
    reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 28; c++) begin
      int s, k;
      s = c % 13;
      k = (c - 2) % 13;
      check("t1_sram_we", sram_we, 0);
      check("t1_sram_a", sram_a, (s < 12) ? s * 32 : 0);
      if (c >= 2 && k != 12) begin
        check("t1_wave_valid", wave_valid, 1);
        check("t1_wave_ch", wave_ch, k);
        check("t1_wave_data", wave_data, 16 + k);
      end else begin
        check("t1_wave_idle", wave_valid, 0);
      end
      tick;
    end

    // 2: in-range write, then the channel picks it up
    wait_slot(5);
    cpu_op(1'b1, 9'd37, 9'd37, 8'hA5, q, lat, wn, wa, wl);
    check("t2_we_count", wn, 1);
    check("t2_we_addr", wa, 37);
    check("t2_we_lat", wl, 7);
    check("t2_ack_lat", lat, 8);
    check("t2_mem37", mem[37], 8'hA5);
    ch_phase[9:5] = 5'd5;
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      if (wave_valid && wave_ch == 4'd1) begin
        lat = n;
        check("t2_ch1_sample", wave_data, 8'hA5);
        break;
      end
      tick;
    end
    check("t2_ch1_seen", 32'(lat >= 0), 1);

    // 3: in-range read
    wait_slot(3);
    cpu_op(1'b0, 9'd37, 9'd37, 8'h00, q, lat, wn, wa, wl);
    check("t3_no_we", wn, 0);
    check("t3_ack_lat", lat, 11);
    check("t3_cpu_q", q, 8'hA5);

    // 4: out-of-range write then read, worst-case slot alignment
    wait_slot(12);
    cpu_op(1'b1, 9'd400, 9'd400, 8'h3C, q, lat, wn, wa, wl);
    check("t4_wr_no_we", wn, 0);
    check("t4_wr_ack_lat", lat, 14);
    wait_slot(12);
    cpu_op(1'b0, 9'd400, 9'd400, 8'h00, q, lat, wn, wa, wl);
    check("t4_rd_no_we", wn, 0);
    check("t4_rd_ack_lat", lat, 15);
    check("t4_rd_cpu_q", q, 8'hFF);

    // 5: only ch0 enabled; address changed after acceptance is ignored
    ch_enable = 12'h001;
    wait_slot(1);
    cpu_op(1'b0, 9'd37, 9'd10, 8'h00, q, lat, wn, wa, wl);
    check("t5_ack_lat", lat, 13);
    check("t5_cpu_q", q, 8'hA5);
    tick; tick;
    cnt_other = 0; cnt_ch0 = 0;
    for (int n = 0; n < 26; n++) begin
      if (wave_valid && wave_ch != 4'd0) cnt_other++;
      if (wave_valid && wave_ch == 4'd0) begin
        cnt_ch0++;
        check("t5_ch0_data", wave_data, 8'h10);
      end
      tick;
    end
    check("t5_other_ch", cnt_other, 0);
    check("t5_ch0_count", cnt_ch0, 2);

    // 6: reset one cycle before a read ack
    ch_enable = 12'hFFF;
    wait_slot(0);
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.a = 9'd37;
    repeat (13) tick;
    check("t6_pre_ack", cpu.ack, 0);
    reset = 1'b1;
    cpu.req = 1'b0;
    #1;
    check("t6_rst_wave_valid", wave_valid, 0);
    check("t6_rst_cpu_ack", cpu.ack, 0);
    check("t6_rst_cpu_q", cpu.q, 0);
    check("t6_rst_wave_data", wave_data, 0);
    check("t6_rst_wave_ch", wave_ch, 0);
    check("t6_rst_sram_we", sram_we, 0);
    tick; tick;
    check("t6_rst_ack_hold", cpu.ack, 0);
    reset = 1'b0;
    cyc = 0;
    cnt_ack = 0;
    for (int c = 0; c < 15; c++) begin
      int s, k;
      s = c % 13;
      k = c - 2;
      if (cpu.ack) cnt_ack++;
      check("t6_sram_a", sram_a, (s == 12) ? 0 : (s == 1) ? 37 : s * 32);
      if (c >= 2 && k < 12) begin
        check("t6_wave_valid", wave_valid, 1);
        check("t6_wave_ch", wave_ch, k);
        check("t6_wave_data", wave_data, (k == 1) ? 8'hA5 : 16 + k);
      end else begin
        check("t6_wave_idle", wave_valid, 0);
      end
      tick;
    end
    check("t6_no_ack", cnt_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
